sensor_sample_ctrl: RTL and testbench

// - Sequences the external sensor and buffers its samples for the AXI slave wrapper.
// - Drives sensor_en, captures each sensor_out word on sensor_ready into a DEPTH-word buffer.
// - Raises sctrl_int when the buffer is full, and holds it until software clears it.
// - The wrapper reads samples through a direct read port and decodes enable/clear writes.

---
 rtl/sensor_pkg.sv | 15 +
 rtl/sensor_buf.sv | 29 ++
 rtl/sensor_sample_ctrl.sv | 142 ++++++++++++++
 tb/tb_sensor_sample_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and default parameters for the sensor sampling controller.
package sensor_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BACKOFF,
        S_FULL
    } sctrl_state_e;

    localparam int DEPTH_DEF   = 64;
    localparam int TIMEOUT_DEF = 1024;
    localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/sensor_buf.sv
// DEPTH x DATA_W sample store: one synchronous write port, one asynchronous read port.
// Kept separate so an SRAM macro can replace it later; read latency then becomes 1.
module sensor_buf
    import sensor_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are deliberately not reset; unwritten words read as X.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sensor_sample_ctrl.sv
// Sensor request sequencer: issues sensor_en, captures samples into sensor_buf,
// raises a level interrupt when the buffer is full, flags sensor timeouts.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | sensor off, waiting for enable with room in the buffer
//  S_REQ     | sensor_en high, waiting for sensor_ready, timeout running
//  S_BACKOFF | one idle cycle after a timeout before re-issuing the request
//  S_FULL    | buffer full, interrupt asserted until software clears
module sensor_sample_ctrl
    import sensor_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sctrl_en_i,
    input  logic              sctrl_clear_i,
    input  logic [ADDR_W-1:0] sctrl_addr_i,
    output logic [DATA_W-1:0] sctrl_out_o,
    output logic              sctrl_int_o,
    output logic [ADDR_W:0]   sample_cnt_o,
    output logic              sensor_err_o,
    input  logic              sensor_ready_i,
    input  logic [DATA_W-1:0] sensor_out_i,
    output logic              sensor_en_o
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0]  CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    sctrl_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              err_q, err_d;
    logic              int_q, int_d;
    logic              sen_q, sen_d;
    logic              wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            int_q   <= 1'b0;
            sen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            int_q   <= int_d;
            sen_q   <= sen_d;
        end
    end

    // Timer defaults to zero; it only advances while waiting in S_REQ.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        err_d   = err_q;
        wr_en   = 1'b0;

        if (sctrl_clear_i) begin
            wptr_d  = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = sctrl_en_i ? S_REQ : S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (sctrl_en_i && (cnt_q <= CNT_LAST)) begin
                        state_d = S_REQ;
                    end
                end
                S_REQ: begin
                    if (sensor_ready_i) begin
                        wr_en  = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_FULL;
                        end else if (sctrl_en_i) begin
                            state_d = S_REQ;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (timer_q == TMR_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_BACKOFF;
                    end else if (!sctrl_en_i) begin
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_BACKOFF: begin
                    state_d = sctrl_en_i ? S_REQ : S_IDLE;
                end
                S_FULL: begin
                    state_d = S_FULL;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Registered outputs track the state being entered.
        sen_d = (state_d == S_REQ);
        int_d = (state_d == S_FULL);
    end

    sensor_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wptr_q),
        .wdata_i (sensor_out_i),
        .raddr_i (sctrl_addr_i),
        .rdata_o (sctrl_out_o)
    );

    assign sctrl_int_o  = int_q;
    assign sample_cnt_o = cnt_q;
    assign sensor_err_o = err_q;
    assign sensor_en_o  = sen_q;

endmodule

// File: tb/tb_sensor_sample_ctrl.sv
// Directed bench for sensor_sample_ctrl with DEPTH=64, TIMEOUT=16.
module tb_sensor_sample_ctrl;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sctrl_en_i = 1'b0;
    logic              sctrl_clear_i = 1'b0;
    logic [ADDR_W-1:0] sctrl_addr_i = '0;
    logic [DATA_W-1:0] sctrl_out_o;
    logic              sctrl_int_o;
    logic [ADDR_W:0]   sample_cnt_o;
    logic              sensor_err_o;
    logic              sensor_ready_i = 1'b0;
    logic [DATA_W-1:0] sensor_out_i = '0;
    logic              sensor_en_o;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sensor_sample_ctrl #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sctrl_en_i     (sctrl_en_i),
        .sctrl_clear_i  (sctrl_clear_i),
        .sctrl_addr_i   (sctrl_addr_i),
        .sctrl_out_o    (sctrl_out_o),
        .sctrl_int_o    (sctrl_int_o),
        .sample_cnt_o   (sample_cnt_o),
        .sensor_err_o   (sensor_err_o),
        .sensor_ready_i (sensor_ready_i),
        .sensor_out_i   (sensor_out_i),
        .sensor_en_o    (sensor_en_o)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Wait for the request, let `gap` cycles pass, then return one ready pulse.
    task automatic capture(input logic [DATA_W-1:0] d, input int gap);
        int n = 0;
        while (sensor_en_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("capture_wait_en", 64'(sensor_en_o), 64'd1);
        repeat (gap) tick();
        sensor_ready_i = 1'b1;
        sensor_out_i   = d;
        tick();
        sensor_ready_i = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [DATA_W-1:0] exp);
        sctrl_addr_i = ADDR_W'(a);
        #1;
        chk(tag, 64'(sctrl_out_o), 64'(exp));
    endtask

    task automatic clear_pulse();
        sctrl_clear_i = 1'b1;
        tick();
        sctrl_clear_i = 1'b0;
    endtask

    initial begin
        int hi;

        // Reset state
        repeat (3) tick();
        chk("rst_en", 64'(sensor_en_o), 64'd0);
        chk("rst_int", 64'(sctrl_int_o), 64'd0);
        chk("rst_cnt", 64'(sample_cnt_o), 64'd0);
        chk("rst_err", 64'(sensor_err_o), 64'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_en", 64'(sensor_en_o), 64'd0);

        // Fill the whole buffer
        sctrl_en_i = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) capture(DATA_W'(32'h100 + i), 2);
        chk("fill63_cnt", 64'(sample_cnt_o), 64'd63);
        chk("fill63_int", 64'(sctrl_int_o), 64'd0);
        capture(32'h13F, 2);
        chk("fill_cnt", 64'(sample_cnt_o), 64'd64);
        chk("fill_int", 64'(sctrl_int_o), 64'd1);
        chk("fill_en", 64'(sensor_en_o), 64'd0);
        sensor_ready_i = 1'b1;
        sensor_out_i   = 32'hBAD0;
        tick();
        sensor_ready_i = 1'b0;
        tick();
        chk("full_ignore_cnt", 64'(sample_cnt_o), 64'd64);
        chk("full_hold_int", 64'(sctrl_int_o), 64'd1);
        for (int a = 0; a < DEPTH; a++) rd("fill_rd", a, DATA_W'(32'h100 + a));

        // Clear with enable held: restart at address 0
        clear_pulse();
        chk("clr_int", 64'(sctrl_int_o), 64'd0);
        chk("clr_cnt", 64'(sample_cnt_o), 64'd0);
        chk("clr_en", 64'(sensor_en_o), 64'd1);
        capture(32'hAAAA, 2);
        chk("clr_cnt1", 64'(sample_cnt_o), 64'd1);
        rd("clr_rd0", 0, 32'hAAAA);
        rd("clr_rd1", 1, 32'h101);

        // Disable coinciding with the sixth sample
        clear_pulse();
        for (int i = 0; i < 5; i++) capture(DATA_W'(32'h500 + i), 2);
        repeat (2) tick();
        sensor_ready_i = 1'b1;
        sensor_out_i   = 32'h505;
        sctrl_en_i     = 1'b0;
        tick();
        sensor_ready_i = 1'b0;
        chk("dis_cnt", 64'(sample_cnt_o), 64'd6);
        chk("dis_en", 64'(sensor_en_o), 64'd0);
        rd("dis_rd5", 5, 32'h505);
        sensor_ready_i = 1'b1;
        sensor_out_i   = 32'hBAD1;
        tick();
        sensor_ready_i = 1'b0;
        tick();
        chk("idle_ignore_cnt", 64'(sample_cnt_o), 64'd6);
        chk("idle_en_low", 64'(sensor_en_o), 64'd0);
        sctrl_en_i = 1'b1;
        capture(32'h600, 3);
        chk("reen_cnt", 64'(sample_cnt_o), 64'd7);
        rd("reen_rd6", 6, 32'h600);

        // Clear colliding with a capture at cnt=10
        clear_pulse();
        for (int i = 0; i < 10; i++) capture(DATA_W'(32'h700 + i), 1);
        chk("col_pre_cnt", 64'(sample_cnt_o), 64'd10);
        sensor_ready_i = 1'b1;
        sensor_out_i   = 32'hDEAD;
        sctrl_clear_i  = 1'b1;
        tick();
        sensor_ready_i = 1'b0;
        sctrl_clear_i  = 1'b0;
        chk("col_cnt", 64'(sample_cnt_o), 64'd0);
        chk("col_en", 64'(sensor_en_o), 64'd1);
        rd("col_rd10", 10, 32'h10A);
        rd("col_rd9", 9, 32'h709);

        // Timeout: 16 cycles requesting, 1 cycle backoff, request again
        sctrl_en_i = 1'b0;
        clear_pulse();
        chk("to_idle_en", 64'(sensor_en_o), 64'd0);
        chk("to_err0", 64'(sensor_err_o), 64'd0);
        sctrl_en_i = 1'b1;
        tick();
        hi = 0;
        while (sensor_en_o === 1'b1 && hi < 100) begin
            hi++;
            tick();
        end
        chk("to_hi_cycles", 64'(hi), 64'd16);
        chk("to_backoff_en", 64'(sensor_en_o), 64'd0);
        chk("to_err1", 64'(sensor_err_o), 64'd1);
        tick();
        chk("to_rereq_en", 64'(sensor_en_o), 64'd1);
        repeat (5) tick();
        chk("to_err_sticky", 64'(sensor_err_o), 64'd1);
        clear_pulse();
        chk("to_err_clr", 64'(sensor_err_o), 64'd0);

        // Asynchronous reset in the middle of a burst
        clear_pulse();
        for (int i = 0; i < 20; i++) capture(DATA_W'(32'h900 + i), 2);
        chk("rb_cnt", 64'(sample_cnt_o), 64'd20);
        chk("rb_en", 64'(sensor_en_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_en", 64'(sensor_en_o), 64'd0);
        chk("ar_cnt", 64'(sample_cnt_o), 64'd0);
        chk("ar_int", 64'(sctrl_int_o), 64'd0);
        chk("ar_err", 64'(sensor_err_o), 64'd0);
        sctrl_en_i = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("ar_idle_en", 64'(sensor_en_o), 64'd0);
        sctrl_en_i = 1'b1;
        tick();
        chk("ar_req_en", 64'(sensor_en_o), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
